// File: rtl/arya_mem_loader_if.sv
// Bundles the arya loader's host stream, core memory port and status signals.
// The loader owns the master modport; host/core models use the slave modport.
interface arya_mem_loader_if #(
    parameter int DPW = 64,
    parameter int MAW = 10
);
    logic           start;
    logic           mode;
    logic [MAW-1:0] base_addr;
    logic [MAW:0]   word_count;
    logic           in_valid;
    logic [DPW-1:0] in_data;
    logic           in_ready;
    logic [MAW-1:0] mem_addr_out;
    logic [DPW-1:0] mem_wdata_out;
    logic           setup_mem;
    logic           verify_mem;
    logic [DPW-1:0] mem_rdata_in;
    logic           core_en;
    logic           busy;
    logic           done;
    logic           error;
    logic [MAW:0]   err_count;
    logic [MAW-1:0] first_err_addr;

    modport master (
        input  start, mode, base_addr, word_count, in_valid, in_data, mem_rdata_in,
        output in_ready, mem_addr_out, mem_wdata_out, setup_mem, verify_mem,
               core_en, busy, done, error, err_count, first_err_addr
    );

    modport slave (
        output start, mode, base_addr, word_count, in_valid, in_data, mem_rdata_in,
        input  in_ready, mem_addr_out, mem_wdata_out, setup_mem, verify_mem,
               core_en, busy, done, error, err_count, first_err_addr
    );
endinterface

// File: rtl/arya_mem_loader.sv
// Host-side loader for the arya setup/verify memory port: streams an image into
// core memory or reads it back and compares against a streamed expected image.
module arya_mem_loader #(
    parameter int DATAPATH_WIDTH = 64,
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int READ_LATENCY   = 1
) (
    input  logic              clk,
    input  logic              reset,
    arya_mem_loader_if.master bus
);
    localparam int          DPW = DATAPATH_WIDTH;
    localparam int          MAW = MEM_ADDR_WIDTH;
    localparam int unsigned RL  = READ_LATENCY;
    localparam logic [MAW:0] CNT_ONE = (MAW+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t         r_state;
    logic [MAW-1:0] r_base;
    logic [MAW:0]   r_count;
    logic [MAW:0]   r_idx;
    logic           r_in_ready;
    logic           r_setup_mem;
    logic           r_busy;
    logic           r_core_en;
    logic           r_done;
    logic           r_error;
    logic [MAW-1:0] r_mem_addr;
    logic [DPW-1:0] r_mem_wdata;
    logic [MAW:0]   r_err_count;
    logic [MAW-1:0] r_first_err_addr;

    // Stage 0 coincides with the verify_mem strobe; stage RL lines up with read data.
    logic [RL:0]    r_dl_vld;
    logic [DPW-1:0] r_dl_exp  [RL+1];
    logic [MAW-1:0] r_dl_addr [RL+1];

    logic           w_accept;
    logic           w_last;
    logic [MAW-1:0] w_addr;
    logic           w_mismatch;
    logic           w_dl_pending;

    assign w_accept     = bus.in_valid & r_in_ready;
    assign w_last       = (r_idx == (r_count - CNT_ONE));
    assign w_addr       = r_base + r_idx[MAW-1:0];
    assign w_mismatch   = r_dl_vld[RL] && (bus.mem_rdata_in != r_dl_exp[RL]);
    assign w_dl_pending = |r_dl_vld[RL-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_base           <= '0;
            r_count          <= '0;
            r_idx            <= '0;
            r_in_ready       <= 1'b0;
            r_setup_mem      <= 1'b0;
            r_busy           <= 1'b0;
            r_core_en        <= 1'b1;
            r_done           <= 1'b0;
            r_error          <= 1'b0;
            r_mem_addr       <= '0;
            r_mem_wdata      <= '0;
            r_err_count      <= '0;
            r_first_err_addr <= '0;
            r_dl_vld         <= '0;
            for (int unsigned i = 0; i <= RL; i++) begin
                r_dl_exp[i]  <= '0;
                r_dl_addr[i] <= '0;
            end
        end else begin
            r_setup_mem <= 1'b0;
            r_done      <= 1'b0;
            r_dl_vld    <= {r_dl_vld[RL-1:0], 1'b0};
            for (int unsigned i = 1; i <= RL; i++) begin
                r_dl_exp[i]  <= r_dl_exp[i-1];
                r_dl_addr[i] <= r_dl_addr[i-1];
            end

            if (w_mismatch) begin
                r_error <= 1'b1;
                if (r_err_count != '1) r_err_count <= r_err_count + CNT_ONE;
                if (!r_error) r_first_err_addr <= r_dl_addr[RL];
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_base           <= bus.base_addr;
                        r_count          <= bus.word_count;
                        r_idx            <= '0;
                        r_error          <= 1'b0;
                        r_err_count      <= '0;
                        r_first_err_addr <= '0;
                        r_busy           <= 1'b1;
                        r_core_en        <= 1'b0;
                        if (bus.word_count == '0) begin
                            r_state <= S_FIN;
                        end else begin
                            r_state    <= bus.mode ? S_READ : S_WRITE;
                            r_in_ready <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (w_accept) begin
                        r_setup_mem <= 1'b1;
                        r_mem_addr  <= w_addr;
                        r_mem_wdata <= bus.in_data;
                        r_idx       <= r_idx + CNT_ONE;
                        if (w_last) begin
                            r_state    <= S_FIN;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                S_READ: begin
                    if (w_accept) begin
                        r_dl_vld[0]  <= 1'b1;
                        r_dl_exp[0]  <= bus.in_data;
                        r_dl_addr[0] <= w_addr;
                        r_mem_addr   <= w_addr;
                        r_idx        <= r_idx + CNT_ONE;
                        if (w_last) begin
                            r_state    <= S_DRAIN;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    // The final compare lands on the same edge we leave, so done trails it.
                    if (!w_dl_pending) r_state <= S_FIN;
                end
                S_FIN: begin
                    r_done    <= 1'b1;
                    r_state   <= S_IDLE;
                    r_busy    <= 1'b0;
                    r_core_en <= 1'b1;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                    r_core_en  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready       = r_in_ready;
    assign bus.mem_addr_out   = r_mem_addr;
    assign bus.mem_wdata_out  = r_mem_wdata;
    assign bus.setup_mem      = r_setup_mem;
    assign bus.verify_mem     = r_dl_vld[0];
    assign bus.core_en        = r_core_en;
    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.error          = r_error;
    assign bus.err_count      = r_err_count;
    assign bus.first_err_addr = r_first_err_addr;
endmodule
